// File: rtl/mac_accumulator_pkg.sv
// Shared constants for the MAC datapath: FSM state encodings and default widths.
// The future MAC top imports this alongside the accumulator.
package mac_accumulator_pkg;

  localparam int MAC_PROD_W = 4;
  localparam int MAC_ACC_W  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/mac_product_counter.sv
// Counts accepted products for one accumulation.
// tc flags the enable cycle that accepts the last product.
module mac_product_counter #(
  parameter int N_PROD = 8,
  parameter int CNT_W  = $clog2(N_PROD + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PROD - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign tc = en && (count == LAST);

endmodule

// File: rtl/mac_accumulator.sv
// Sums N_PROD unsigned products into an ACC_W-bit accumulator, then pulses done.
// overflow is sticky across the operation and cleared only by an accepted start or reset.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int PROD_W = MAC_PROD_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int N_PROD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  logic [1:0]     state;
  logic           accept;
  logic           clr_cnt;
  logic           last;
  logic [ACC_W:0] sum;

  assign accept  = (state == ST_ACCUM) && prod_valid;
  assign clr_cnt = (state == ST_IDLE) && start;
  // Extra MSB is the carry out that feeds the sticky overflow.
  assign sum     = {1'b0, acc_out} + (ACC_W+1)'(prod);

  mac_product_counter #(
    .N_PROD (N_PROD)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .en  (accept),
    .tc  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ST_ACCUM;
            acc_out  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (prod_valid) begin
            acc_out <= sum[ACC_W-1:0];
            if (sum[ACC_W]) overflow <= 1'b1;
            if (last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: dut8 (ACC_W=8) and dut6 (ACC_W=6) share stimulus with N_PROD=8;
// dut1 exercises N_PROD=1 on its own inputs.
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, prod_valid;
  logic [3:0] prod;
  logic       start1, prod_valid1;
  logic [3:0] prod1;

  logic [7:0] acc8, acc1;
  logic [5:0] acc6;
  logic       busy8, done8, ovf8;
  logic       busy6, done6, ovf6;
  logic       busy1, done1, ovf1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.PROD_W(4), .ACC_W(8), .N_PROD(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .prod_valid(prod_valid), .prod(prod),
    .acc_out(acc8), .busy(busy8), .done(done8), .overflow(ovf8));

  mac_accumulator #(.PROD_W(4), .ACC_W(6), .N_PROD(8)) dut6 (
    .clk(clk), .rst(rst), .start(start), .prod_valid(prod_valid), .prod(prod),
    .acc_out(acc6), .busy(busy6), .done(done6), .overflow(ovf6));

  mac_accumulator #(.PROD_W(4), .ACC_W(8), .N_PROD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .prod_valid(prod_valid1), .prod(prod1),
    .acc_out(acc1), .busy(busy1), .done(done1), .overflow(ovf1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full 8-product operation on dut8/dut6 with optional bubbles and ignored starts.
  task automatic run8(input string tag, input int vals[8], input int bub,
                      input bit start_accum, input bit start_done,
                      input int e_acc8, input int e_acc6, input int e_ovf6);
    start = 1'b1; prod_valid = 1'b0; prod = 4'd0;
    tick();
    start = 1'b0;
    chk({tag, ":busy_after_start"}, busy8, 1);
    chk({tag, ":acc_cleared"}, acc6, 0);
    chk({tag, ":ovf_cleared"}, ovf6, 0);
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < bub; b++) begin
        start = start_accum; prod_valid = 1'b0; prod = 4'd9;
        tick();
        chk({tag, ":no_done_bubble"}, done8, 0);
      end
      start = start_accum; prod_valid = 1'b1; prod = 4'(vals[i]);
      tick();
      if (i < 7) begin
        chk({tag, ":no_early_done"}, done8, 0);
        chk({tag, ":busy_mid"}, busy8, 1);
      end
    end
    start = start_done; prod_valid = 1'b0; prod = 4'd9;
    chk({tag, ":done8"}, done8, 1);
    chk({tag, ":done6"}, done6, 1);
    chk({tag, ":busy_in_done"}, busy8, 0);
    chk({tag, ":acc8"}, acc8, e_acc8);
    chk({tag, ":acc6"}, acc6, e_acc6);
    chk({tag, ":ovf8"}, ovf8, 0);
    chk({tag, ":ovf6"}, ovf6, e_ovf6);
    tick();
    start = 1'b0;
    chk({tag, ":done_single"}, done8, 0);
    chk({tag, ":idle_busy"}, busy8, 0);
    tick();
    chk({tag, ":idle_no_restart"}, busy8, 0);
    chk({tag, ":idle_hold_acc"}, acc8, e_acc8);
  endtask

  initial begin
    int p_basic[8] = '{1, 2, 3, 4, 6, 9, 0, 9};
    int p_nine[8]  = '{9, 9, 9, 9, 9, 9, 9, 9};
    int p_one[8]   = '{1, 1, 1, 1, 1, 1, 1, 1};
    int p_two[8]   = '{2, 2, 2, 2, 2, 2, 2, 2};

    start1 = 1'b0; prod_valid1 = 1'b0; prod1 = 4'd0;
    rst = 1'b0;
    start = 1'b1; prod_valid = 1'b1; prod = 4'd7;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      prod = 4'($urandom_range(0, 15)); prod_valid = 1'($urandom);
      tick();
    end
    rst = 1'b1; start = 1'b0; prod_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset:acc8", acc8, 0);
    chk("reset:busy8", busy8, 0);
    chk("reset:done8", done8, 0);
    chk("reset:ovf8", ovf8, 0);
    chk("reset:acc6", acc6, 0);
    chk("reset:busy1", busy1, 0);

    run8("basic", p_basic, 0, 1'b0, 1'b0, 34, 34, 0);
    run8("bubbles", p_basic, 3, 1'b0, 1'b0, 34, 34, 0);
    run8("overflow", p_nine, 0, 1'b0, 1'b0, 72, 8, 1);
    run8("ovf_clear", p_one, 0, 1'b0, 1'b0, 8, 8, 0);
    run8("ign_start", p_basic, 1, 1'b1, 1'b1, 34, 34, 0);
    run8("fresh", p_one, 0, 1'b0, 1'b0, 8, 8, 0);

    // Abort mid-operation after 4 products.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod_valid = 1'b1; prod = 4'd9; tick();
    end
    prod_valid = 1'b0;
    chk("midrst:acc_before", acc8, 36);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst:acc8", acc8, 0);
    chk("midrst:busy8", busy8, 0);
    chk("midrst:done8", done8, 0);
    chk("midrst:ovf6", ovf6, 0);
    run8("after_rst", p_two, 0, 1'b0, 1'b0, 16, 16, 0);

    // N_PROD=1: first accepted product completes the operation.
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("n1:busy", busy1, 1);
    prod_valid1 = 1'b0; prod1 = 4'd9; tick();
    chk("n1:bubble_no_done", done1, 0);
    prod_valid1 = 1'b1; prod1 = 4'd13; tick();
    prod_valid1 = 1'b0;
    chk("n1:done", done1, 1);
    chk("n1:acc", acc1, 13);
    chk("n1:busy_done", busy1, 0);
    tick();
    chk("n1:done_single", done1, 0);
    chk("n1:acc_hold", acc1, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
